mixer_nlevel_dec: RTL
=====================

# mixer_nlevel_dec

Parametrised multi-level RF mixer with integrate-and-dump decimation for the 1-bit/few-bit AM receiver chain. It takes an offset-binary RF level code from the comparator/ladder front end and the NCO sine/cosine. It produces the quadrature products, sums them over a runtime-selectable number of samples, and emits one I/Q pair per frame with a valid strobe. It sits between the NCO/RF front end and the CIC/low-pass decimation stages, and also regenerates the 1-bit `RF_out` feedback bit.

## Interface
- `BITS`, 16: NCO sample width (signed `sin_in`/`cos_in`).
- `RF_BITS`, 3: width of the RF level code.
- `MID_LOG2`, 1: log2 of the mid-scale code; MID = 2^MID_LOG2. Valid codes are 0..2·MID, which requires 2·MID ≤ 2^RF_BITS−1.
- `DEC_BITS`, 8: width of the decimation ratio.
- Derived widths:
  - MIX_W = BITS+1.
  - ACC_W = MIX_W+DEC_BITS.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  qualifies `RF_in`/`sin_in`/`cos_in` this cycle.
- `RF_in`  in  RF_BITS  offset-binary RF level code.
- `sin_in`, `cos_in`  in  BITS  signed NCO samples.
- `dec_ratio`  in  DEC_BITS  samples per output frame; 0 and 1 both mean 1.
- `clr`  in  1  synchronous flush of the partial frame.
- `RF_out`  out  1  registered 1-bit RF feedback.
- `I_out`, `Q_out`  out  ACC_W  signed decimated sums.
- `out_valid`  out  1  one-cycle strobe marking new `I_out`/`Q_out`.

## Operation
- Stage 1 (input register):
  - Capture `RF_in`, `sin_in`, `cos_in`, `in_valid` every cycle.
  - Clamp the code: any code > 2·MID is treated as 2·MID.
- Stage 2 (mix), registered:
  - d = code − MID, signed, range −MID..+MID.
  - I_mix = (d·cos) >>> MID_LOG2; Q_mix = (d·sin) >>> MID_LOG2.
  - Arithmetic shift, truncating toward −∞.
  - Both are MIX_W wide, so d=−MID with cos=−2^(BITS−1) gives +2^(BITS−1) with no overflow.
  - Valid flag piped alongside.
- `RF_out` is registered from the stage-1 code: 1 if code ≥ MID, else 0. It updates every cycle regardless of `in_valid`.
- Stage 3 (integrate-and-dump): states IDLE and ACCUM.
  - **IDLE:**
    - Accumulators and count are 0.
    - `dec_ratio` is latched here as N (0→1).
    - A valid mix sample loads acc = mix and sets count = 1.
    - If N = 1, the frame dumps immediately and the block stays in IDLE; otherwise it goes to ACCUM.
  - **ACCUM:**
    - Each valid sample does acc += mix and count += 1.
    - When count reaches N, `I_out`/`Q_out` take acc+mix, `out_valid` pulses, and the block returns to IDLE.
    - Cycles with an invalid mix sample hold acc and count.
- `dec_ratio` changes while in ACCUM have no effect until the next IDLE latch.
- Accumulation never overflows: |sum| ≤ N·2^(BITS−1) < 2^(ACC_W−1).
- `clr`:
  - Acts in the stage-3 cycle it is sampled: acc and count go to 0 and state goes to IDLE.
  - Any sample arriving at stage 3 in that cycle is discarded.
  - If `clr` coincides with a frame-completing sample, `clr` wins: no `out_valid`, and outputs hold their previous values.
  - Stages 1–2 are not flushed.
- `I_out`/`Q_out` hold their value between strobes.

## Timing
- Reset values:
  - `RF_out`, `out_valid`, `I_out`, `Q_out` = 0.
  - All pipeline registers and valid flags = 0; state = IDLE.
- Reset asserted mid-frame discards the partial frame and every in-flight pipeline sample; no `out_valid` follows from pre-reset samples.
- Latency:
  - Sample at cycle t reaches stage 1 at t+1 and the mix register at t+2.
  - The accumulator includes it at t+3.
  - For the last sample of a frame, `out_valid` is high at t+3 with data.
- `RF_out` reflects `RF_in` of cycle t at cycle t+2.
- Throughput: one sample per clock; back-to-back frames need no gap. With N=1, `out_valid` can be high on consecutive cycles.

## Test plan
- **Reset state:** hold `RST` 3 cycles → all outputs 0.
  - Then N=4, code 4 (MID=2), cos=1000, sin=−200, 4 valid cycles → one strobe, I_out=4000, Q_out=−800, exactly 3 cycles after the 4th input.
- **Level scaling and truncation:** N=1, codes 0,1,2,3,4 with cos=1001 → I_out −1001, −501, 0, 500, 1001 on consecutive cycles.
  - Also: code 7 → 1001 (clamp).
  - Also: `RF_out` sequence 0,0,1,1,1,1 at 2-cycle latency.
- **Full-scale corner:** N=1, code 0, cos=−32768 → I_out=+32768 (no wrap).
  - Then N=255, all samples code 4, cos=32767 → I_out=8355585.
- **Gapped input and ratio change:** N=3 with `in_valid` pattern 1,0,1,0,0,1, code 4, cos=10 → single strobe, I_out=30.
  - Change `dec_ratio` to 2 mid-frame → current frame still uses 3 samples; the next frame uses 2.
- **Flush and collisions:**
  - `clr` concurrent with the 3rd sample of an N=3 frame → no strobe, outputs unchanged, next frame sums only subsequent samples.
  - `RST` pulsed mid-frame with samples in flight → no strobe from pre-reset data.

Source files
------------

// File: rtl/mixer_nlevel_dec.sv
// Multi-level RF mixer with integrate-and-dump decimation.
// Produces one I/Q sum per frame of N valid samples, plus 1-bit RF feedback.
module mixer_nlevel_dec #(
  parameter int BITS     = 16,
  parameter int RF_BITS  = 3,
  parameter int MID_LOG2 = 1,
  parameter int DEC_BITS = 8,
  localparam int MIX_W   = BITS + 1,
  localparam int ACC_W   = MIX_W + DEC_BITS
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  input  logic [RF_BITS-1:0]      RF_in,
  input  logic signed [BITS-1:0]  sin_in,
  input  logic signed [BITS-1:0]  cos_in,
  input  logic [DEC_BITS-1:0]     dec_ratio,
  input  logic                    clr,
  output logic                    RF_out,
  output logic signed [ACC_W-1:0] I_out,
  output logic signed [ACC_W-1:0] Q_out,
  output logic                    out_valid
);

  localparam int MID = 1 << MID_LOG2;
  localparam logic [RF_BITS-1:0] MAXC = RF_BITS'(2 * MID);
  localparam logic [RF_BITS-1:0] MIDC = RF_BITS'(MID);

  typedef enum logic {IDLE, ACCUM} state_t;

  logic [RF_BITS-1:0]      code_r;
  logic signed [BITS-1:0]  sin_r;
  logic signed [BITS-1:0]  cos_r;
  logic                    v1;

  logic signed [RF_BITS:0]      d;
  logic signed [BITS+RF_BITS:0] prod_i;
  logic signed [BITS+RF_BITS:0] prod_q;
  logic signed [MIX_W-1:0]      mix_i;
  logic signed [MIX_W-1:0]      mix_q;
  logic                         v2;

  state_t                  state, state_n;
  logic signed [ACC_W-1:0] acc_i, acc_i_n;
  logic signed [ACC_W-1:0] acc_q, acc_q_n;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic [DEC_BITS-1:0]     cnt, cnt_n;
  logic [DEC_BITS-1:0]     n_r, n_n, n_eff;
  logic                    dump;

  // Input register with code clamp; RF feedback follows the clamped code.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_r <= '0;
      sin_r  <= '0;
      cos_r  <= '0;
      v1     <= 1'b0;
      RF_out <= 1'b0;
    end else begin
      code_r <= (RF_in > MAXC) ? MAXC : RF_in;
      sin_r  <= sin_in;
      cos_r  <= cos_in;
      v1     <= in_valid;
      RF_out <= (code_r >= MIDC);
    end
  end

  assign d      = $signed({1'b0, code_r}) - $signed({1'b0, MIDC});
  assign prod_i = d * cos_r;
  assign prod_q = d * sin_r;

  // Mix register: signed level times NCO, scaled down by MID (floor).
  always_ff @(posedge CLK) begin
    if (RST) begin
      mix_i <= '0;
      mix_q <= '0;
      v2    <= 1'b0;
    end else begin
      mix_i <= MIX_W'(prod_i >>> MID_LOG2);
      mix_q <= MIX_W'(prod_q >>> MID_LOG2);
      v2    <= v1;
    end
  end

  assign n_eff = (state == ACCUM) ? n_r :
                 (dec_ratio == '0) ? DEC_BITS'(1) : dec_ratio;
  assign sum_i = acc_i + ACC_W'(mix_i);
  assign sum_q = acc_q + ACC_W'(mix_q);

  // Integrate-and-dump next state; clr beats a completing sample.
  always_comb begin
    state_n = state;
    acc_i_n = acc_i;
    acc_q_n = acc_q;
    cnt_n   = cnt;
    n_n     = n_eff;
    dump    = 1'b0;
    if (clr) begin
      state_n = IDLE;
      acc_i_n = '0;
      acc_q_n = '0;
      cnt_n   = '0;
    end else if (v2) begin
      if (DEC_BITS'(cnt + 1'b1) == n_eff) begin
        dump    = 1'b1;
        state_n = IDLE;
        acc_i_n = '0;
        acc_q_n = '0;
        cnt_n   = '0;
      end else begin
        state_n = ACCUM;
        acc_i_n = sum_i;
        acc_q_n = sum_q;
        cnt_n   = cnt + 1'b1;
      end
    end
  end

  // Frame state, accumulators and held outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      n_r       <= DEC_BITS'(1);
      out_valid <= 1'b0;
      I_out     <= '0;
      Q_out     <= '0;
    end else begin
      state     <= state_n;
      acc_i     <= acc_i_n;
      acc_q     <= acc_q_n;
      cnt       <= cnt_n;
      n_r       <= n_n;
      out_valid <= dump;
      if (dump) begin
        I_out <= sum_i;
        Q_out <= sum_q;
      end
    end
  end

endmodule
